// File: rtl/controle_jogada.sv
// controle_jogada: takes one button press per move while jogar is high, checks the cell through a
// sync-read board memory and pulses accept / reject / timeout. Optional input filter: DEBOUNCE_EN.
module controle_jogada #(
  parameter int TIMEOUT_CICLOS = 250000000
`ifdef DEBOUNCE_EN
  , parameter int DEBOUNCE_CICLOS = 1000000
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic [8:0] botoes,
  input  logic [3:0] base_addr,
  input  logic [1:0] celula_dado,
  output logic [7:0] celula_addr,
  output logic [3:0] jogada_pos,
  output logic       tem_jogada,
  output logic       jogada_invalida,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    OCIOSO   = 4'd0,
    ESPERA   = 4'd1,
    LE_MEM   = 4'd2,
    AGUARDA  = 4'd3,
    VALIDA   = 4'd4,
    ACEITA   = 4'd5,
    INVALIDA = 4'd6,
    SOLTA    = 4'd7,
    TEMPO    = 4'd8
  } estado_t;

  localparam logic [27:0] LIMITE = 28'(TIMEOUT_CICLOS - 1);

  estado_t     r_estado;
  logic [27:0] r_timer;
  logic [3:0]  r_pos;
  logic [8:0]  w_botoes;
  logic [3:0]  w_indice;
  logic        w_unico;

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CW-1:0] ESTAVEL = CW'(DEBOUNCE_CICLOS);

  logic [CW-1:0] r_filtro [9];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) r_filtro[i] <= '0;
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (!botoes[i])                r_filtro[i] <= '0;
        else if (r_filtro[i] != ESTAVEL) r_filtro[i] <= r_filtro[i] + 1'b1;
      end
    end
  end

  // Gating with the raw bit makes release take effect in the same cycle.
  always_comb begin
    w_botoes = '0;
    for (int i = 0; i < 9; i++) w_botoes[i] = botoes[i] && (r_filtro[i] == ESTAVEL);
  end
`else
  assign w_botoes = botoes;
`endif

  always_comb begin
    w_indice = 4'd0;
    for (int i = 0; i < 9; i++) if (w_botoes[i]) w_indice = 4'(i);
  end

  assign w_unico = (w_botoes != 9'd0) && ((w_botoes & (w_botoes - 9'd1)) == 9'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= OCIOSO;
      r_timer  <= '0;
      r_pos    <= '0;
    end else begin
      if (r_estado != OCIOSO && r_estado != ACEITA && r_timer != LIMITE)
        r_timer <= r_timer + 28'd1;

      case (r_estado)
        OCIOSO: if (jogar) begin
          r_estado <= ESPERA;
          r_timer  <= '0;
        end
        ESPERA: begin
          if (!jogar)                 r_estado <= OCIOSO;
          else if (r_timer == LIMITE) r_estado <= TEMPO;
          else if (w_unico) begin
            r_pos    <= w_indice;
            r_estado <= LE_MEM;
          end
        end
        LE_MEM:   r_estado <= jogar ? AGUARDA : OCIOSO;
        AGUARDA:  r_estado <= jogar ? VALIDA : OCIOSO;
        VALIDA: begin
          if (!jogar)                    r_estado <= OCIOSO;
          else if (celula_dado == 2'b00) r_estado <= ACEITA;
          else                           r_estado <= INVALIDA;
        end
        ACEITA: begin
          r_timer  <= '0;
          r_estado <= SOLTA;
        end
        INVALIDA: r_estado <= SOLTA;
        TEMPO:    r_estado <= SOLTA;
        // Raw buttons gate the release so a bouncing key cannot re-arm a move.
        SOLTA:    if (botoes == 9'd0) r_estado <= jogar ? ESPERA : OCIOSO;
        default:  r_estado <= OCIOSO;
      endcase
    end
  end

  assign celula_addr     = {base_addr, r_pos};
  assign jogada_pos      = r_pos;
  assign tem_jogada      = (r_estado == ACEITA);
  assign jogada_invalida = (r_estado == INVALIDA);
  assign timeout         = (r_estado == TEMPO);
  assign db_estado       = r_estado;

endmodule

// File: tb/tb_controle_jogada.sv
// Directed bench for controle_jogada with a 20-cycle move timeout.
module tb_controle_jogada;

  logic       clock = 1'b0;
  logic       reset;
  logic       jogar;
  logic [8:0] botoes;
  logic [3:0] base_addr;
  logic [1:0] celula_dado;
  logic [7:0] celula_addr;
  logic [3:0] jogada_pos;
  logic       tem_jogada;
  logic       jogada_invalida;
  logic       timeout;
  logic [3:0] db_estado;

  int n_pass  = 0;
  int n_total = 0;

  controle_jogada #(
    .TIMEOUT_CICLOS(20)
`ifdef DEBOUNCE_EN
    , .DEBOUNCE_CICLOS(5)
`endif
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes),
    .base_addr(base_addr), .celula_dado(celula_dado), .celula_addr(celula_addr),
    .jogada_pos(jogada_pos), .tem_jogada(tem_jogada), .jogada_invalida(jogada_invalida),
    .timeout(timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Packs {db_estado, tem_jogada, jogada_invalida, timeout} for one-shot state/pulse checks.
  function automatic logic [15:0] st();
    return 16'({db_estado, tem_jogada, jogada_invalida, timeout});
  endfunction

  function automatic logic [15:0] ex(input logic [3:0] e, input logic t, input logic i, input logic o);
    return 16'({e, t, i, o});
  endfunction

  initial begin
    reset = 1'b1; jogar = 1'b0; botoes = '0; base_addr = '0; celula_dado = 2'b00;
    tick(); tick();
    reset = 1'b0;
    chk("reset_state", st(), ex(4'd0, 0, 0, 0));
    chk("reset_pos", 16'(jogada_pos), 16'd0);

    // Valid move on cell 4 of board 3
    base_addr = 4'h3; celula_dado = 2'b00; jogar = 1'b1;
    tick();
    chk("ok_espera", st(), ex(4'd1, 0, 0, 0));
    botoes = 9'b000010000;
    tick();
    chk("ok_le_mem", st(), ex(4'd2, 0, 0, 0));
    chk("ok_addr", 16'(celula_addr), 16'h34);
    chk("ok_pos", 16'(jogada_pos), 16'd4);
    tick();
    chk("ok_aguarda", st(), ex(4'd3, 0, 0, 0));
    tick();
    chk("ok_valida", st(), ex(4'd4, 0, 0, 0));
    tick();
    chk("ok_aceita", st(), ex(4'd5, 1, 0, 0));
    tick();
    chk("ok_solta", st(), ex(4'd7, 0, 0, 0));
    tick();
    chk("ok_held", st(), ex(4'd7, 0, 0, 0));
    botoes = '0;
    tick();
    chk("ok_release", st(), ex(4'd1, 0, 0, 0));

    // Occupied cell 0
    celula_dado = 2'b01; botoes = 9'b000000001;
    tick(); tick(); tick(); tick();
    chk("inv_pulse", st(), ex(4'd6, 0, 1, 0));
    chk("inv_pos", 16'(jogada_pos), 16'd0);
    tick();
    chk("inv_solta", st(), ex(4'd7, 0, 0, 0));
    tick();
    chk("inv_held", st(), ex(4'd7, 0, 0, 0));
    botoes = '0;
    tick();
    chk("inv_release", st(), ex(4'd1, 0, 0, 0));

    // Abort in ESPERA, then a fresh ESPERA with a cleared timer
    jogar = 1'b0;
    tick();
    chk("abort_espera", st(), ex(4'd0, 0, 0, 0));
    jogar = 1'b1; celula_dado = 2'b00;
    tick();

    // Two buttons at once are ignored
    botoes = 9'b000000011;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("multi_%0d", k), st(), ex(4'd1, 0, 0, 0));
    end
    botoes = 9'b000000010;
    tick();
    chk("multi_le_mem", st(), ex(4'd2, 0, 0, 0));
    tick(); tick(); tick();
    chk("multi_aceita", st(), ex(4'd5, 1, 0, 0));
    chk("multi_pos", 16'(jogada_pos), 16'd1);
    botoes = '0;
    tick(); tick();
    chk("multi_release", st(), ex(4'd1, 0, 0, 0));

    // Timeout with no press: pulse 20 cycles after entering ESPERA
    jogar = 1'b0; tick(); jogar = 1'b1; tick();
    repeat (18) tick();
    chk("to_e18", st(), ex(4'd1, 0, 0, 0));
    tick();
    chk("to_e19", st(), ex(4'd1, 0, 0, 0));
    tick();
    chk("to_pulse", st(), ex(4'd8, 0, 0, 1));
    jogar = 1'b0;
    tick();
    chk("to_solta", st(), ex(4'd7, 0, 0, 0));
    tick();
    chk("to_ocioso", st(), ex(4'd0, 0, 0, 0));

    // Press on the expiry cycle: timeout wins
    jogar = 1'b1;
    tick();
    repeat (19) tick();
    botoes = 9'b000000100;
    tick();
    chk("tie_timeout", st(), ex(4'd8, 0, 0, 1));
    chk("tie_pos_kept", 16'(jogada_pos), 16'd1);
    tick();
    chk("tie_solta", st(), ex(4'd7, 0, 0, 0));
    jogar = 1'b0;
    tick();
    chk("tie_held", st(), ex(4'd7, 0, 0, 0));
    botoes = '0;
    tick();
    chk("tie_ocioso", st(), ex(4'd0, 0, 0, 0));

    // Abort in AGUARDA
    jogar = 1'b1; celula_dado = 2'b00;
    tick();
    botoes = 9'b000100000;
    tick(); tick();
    chk("ab_aguarda", st(), ex(4'd3, 0, 0, 0));
    jogar = 1'b0;
    tick();
    chk("ab_ocioso", st(), ex(4'd0, 0, 0, 0));
    botoes = '0;
    tick();
    chk("ab_quiet", st(), ex(4'd0, 0, 0, 0));

    // Reset in the middle of VALIDA
    base_addr = 4'h5; jogar = 1'b1;
    tick();
    botoes = 9'b010000000;
    tick(); tick(); tick();
    chk("rst_valida", st(), ex(4'd4, 0, 0, 0));
    chk("rst_pre_pos", 16'(jogada_pos), 16'd7);
    chk("rst_pre_addr", 16'(celula_addr), 16'h57);
    reset = 1'b1;
    tick();
    chk("rst_state", st(), ex(4'd0, 0, 0, 0));
    chk("rst_pos", 16'(jogada_pos), 16'd0);
    reset = 1'b0; jogar = 1'b0; botoes = '0;
    tick();
    chk("rst_idle", st(), ex(4'd0, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
